// File: rtl/invader_pkg.sv
// Shared types and constants for the digit-invader queue: digit encoding and game states.
package invader_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [3:0] DIGIT_MIN = 4'd1;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Out-of-range or unknown generator values become the lowest legal digit.
  function automatic logic [DIGIT_W-1:0] sanitize_digit(input logic [DIGIT_W-1:0] d);
    if (d >= DIGIT_MIN && d <= DIGIT_MAX) begin
      return d;
    end else begin
      return DIGIT_MIN;
    end
  endfunction

endpackage

// File: rtl/spawn_tick.sv
// Free-running spawn timer: counts 0..SPAWN_DIV-1 while enabled and pulses o_tick on the last count.
module spawn_tick
  import invader_pkg::*;
#(
  parameter int SPAWN_DIV = 100_000_000,
  parameter int SPAWN_W   = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  logic [SPAWN_W-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == SPAWN_W'(SPAWN_DIV - 1));
  assign o_tick = i_en && w_last && !i_clr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + SPAWN_W'(1);
    end
  end

endmodule

// File: rtl/invader_digit_queue.sv
// Ordered invader queue fed by the random digit generator; player shots remove the oldest matching digit.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | spawning invaders and accepting shots
//   OVER  | queue overflowed, slots frozen for display, waiting for start
module invader_digit_queue
  import invader_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int SPAWN_DIV = 100_000_000,
  parameter  int SPAWN_W   = 27,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DIGIT_W-1:0]       i_rnd,
  input  logic                     i_start,
  input  logic                     i_fire,
  input  logic [DIGIT_W-1:0]       i_aim,
  output logic [DIGIT_W*DEPTH-1:0] o_slots,
  output logic [CNT_W-1:0]         o_count,
  output logic                     o_hit,
  output logic                     o_miss,
  output logic [7:0]               o_score,
  output logic                     o_game_over
);

  state_t             r_state;
  logic [DIGIT_W-1:0] r_slot [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_score;
  logic               r_hit;
  logic               r_miss;
  logic               r_game_over;

  logic               w_run;
  logic               w_start_ok;
  logic               w_tick;
  logic               w_shot;
  logic               w_match;
  logic               w_do_hit;
  logic [CNT_W-1:0]   w_hit_idx;
  logic [CNT_W-1:0]   w_count_rm;
  logic               w_overflow;
  logic               w_push;
  logic [CNT_W-1:0]   w_count_nx;
  logic [DIGIT_W-1:0] w_digit;
  logic [DIGIT_W-1:0] w_slot_nx [DEPTH];

  assign w_run      = (r_state == RUN);
  assign w_start_ok = i_start && (r_state != RUN);
  assign w_shot     = i_fire && w_run;
  assign w_do_hit   = w_shot && w_match;
  assign w_digit    = sanitize_digit(i_rnd);

  spawn_tick #(
    .SPAWN_DIV (SPAWN_DIV),
    .SPAWN_W   (SPAWN_W)
  ) u_spawn_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_run),
    .i_clr   (w_start_ok),
    .o_tick  (w_tick)
  );

  // Descending scan so the lowest (oldest) matching slot wins.
  always_comb begin
    w_match   = 1'b0;
    w_hit_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (CNT_W'(k) < r_count && r_slot[k] == i_aim) begin
        w_match   = 1'b1;
        w_hit_idx = CNT_W'(k);
      end
    end
  end

  // Removal happens before the push so a hit frees room for a same-cycle spawn.
  assign w_count_rm = r_count - {{(CNT_W-1){1'b0}}, w_do_hit};
  assign w_overflow = w_tick && (w_count_rm == CNT_W'(DEPTH));
  assign w_push     = w_tick && !w_overflow;
  assign w_count_nx = w_count_rm + {{(CNT_W-1){1'b0}}, w_push};

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_slot_nx[j] = r_slot[j];
      if (w_do_hit && CNT_W'(j) >= w_hit_idx) begin
        w_slot_nx[j] = BLANK;
      end
    end
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (w_do_hit && CNT_W'(j) >= w_hit_idx) begin
        w_slot_nx[j] = r_slot[j+1];
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (w_push && CNT_W'(j) == w_count_rm) begin
        w_slot_nx[j] = w_digit;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_score     <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        r_slot[j] <= BLANK;
      end
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (i_start) begin
            r_state     <= RUN;
            r_count     <= '0;
            r_score     <= '0;
            r_game_over <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
              r_slot[j] <= BLANK;
            end
          end
        end
        RUN: begin
          r_hit  <= w_do_hit;
          r_miss <= w_shot && !w_match;
          if (w_do_hit && r_score != 8'hFF) begin
            r_score <= r_score + 8'd1;
          end
          for (int j = 0; j < DEPTH; j++) begin
            r_slot[j] <= w_slot_nx[j];
          end
          r_count <= w_count_nx;
          if (w_overflow) begin
            r_state     <= OVER;
            r_game_over <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slots
    assign o_slots[DIGIT_W*k +: DIGIT_W] = r_slot[k];
  end

  assign o_count     = r_count;
  assign o_score     = r_score;
  assign o_hit       = r_hit;
  assign o_miss      = r_miss;
  assign o_game_over = r_game_over;

endmodule
